// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter and its neighbours: fetch port, load/store port,
// the shared 8-bit RAM/IO port, plus the arbiter's visible FSM state.
interface mem_arbiter_if;
    logic        rollback_in;
    logic        if_request_in;
    logic [31:0] if_address_in;
    logic        if_ready_out;
    logic [31:0] if_data_out;
    logic        lsb_request_in;
    logic        lsb_rw_in;
    logic [31:0] lsb_address_in;
    logic [2:0]  lsb_goal_in;
    logic [31:0] lsb_data_in;
    logic        lsb_ready_out;
    logic [31:0] lsb_data_out;
    logic [7:0]  ram_din_in;
    logic [7:0]  ram_dout_out;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;
    logic        io_buffer_full_in;
    logic [1:0]  arb_state;

    // Requests are single-cycle pulses with no back-pressure; each requester keeps
    // at most one request outstanding until its one-cycle ready pulse.
    modport master (
        output rollback_in, if_request_in, if_address_in,
        output lsb_request_in, lsb_rw_in, lsb_address_in, lsb_goal_in, lsb_data_in,
        output ram_din_in, io_buffer_full_in,
        input  if_ready_out, if_data_out, lsb_ready_out, lsb_data_out,
        input  ram_dout_out, ram_a_out, ram_wr_out, arb_state
    );

    modport slave (
        input  rollback_in, if_request_in, if_address_in,
        input  lsb_request_in, lsb_rw_in, lsb_address_in, lsb_goal_in, lsb_data_in,
        input  ram_din_in, io_buffer_full_in,
        output if_ready_out, if_data_out, lsb_ready_out, lsb_data_out,
        output ram_dout_out, ram_a_out, ram_wr_out, arb_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Owner of the 8-bit RAM/IO port: serialises fetch and load/store requests into byte
// accesses, assembles reads little-endian, honours rollback and IO back-pressure.
module mem_arbiter (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

    state_t      state;
    logic        if_pend;
    logic [31:0] if_addr_q;
    logic        lsb_pend;
    logic        lsb_rw_q;
    logic [31:0] lsb_addr_q;
    logic [2:0]  lsb_n_q;
    logic [31:0] lsb_data_q;

    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [2:0]  cur_n;
    logic        cur_lsb;
    logic [2:0]  cnt;
    logic [31:0] asm_q;

    logic        if_ready;
    logic [31:0] if_data;
    logic        lsb_ready;
    logic [31:0] lsb_data;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [2:0]  lsb_n_in;
    logic        lsb_new_rw;
    logic [31:0] lsb_new_addr;
    logic [2:0]  lsb_new_n;
    logic [31:0] lsb_new_data;
    logic        lsb_drop;
    logic        lsb_eff;
    logic        if_eff;
    logic [31:0] if_eff_addr;
    logic        grant_lsb;
    logic        grant_if;
    logic [31:0] sel_addr;
    logic        sel_rw;
    logic [2:0]  sel_n;
    logic        sel_io;
    logic [1:0]  byte_idx;
    logic [31:0] asm_next;
    logic [31:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        wr_stall;
    logic        rd_abort;

    always_comb begin
        case (bus.lsb_goal_in)
            3'd1:    lsb_n_in = 3'd1;
            3'd2:    lsb_n_in = 3'd2;
            default: lsb_n_in = 3'd4;
        endcase
        // A pulse this cycle takes precedence over the (necessarily empty) slot.
        lsb_new_rw   = bus.lsb_request_in ? bus.lsb_rw_in      : lsb_rw_q;
        lsb_new_addr = bus.lsb_request_in ? bus.lsb_address_in : lsb_addr_q;
        lsb_new_n    = bus.lsb_request_in ? lsb_n_in           : lsb_n_q;
        lsb_new_data = bus.lsb_request_in ? bus.lsb_data_in    : lsb_data_q;
        lsb_drop     = bus.rollback_in && !lsb_new_rw && (lsb_new_addr[17:16] != 2'b11);
        lsb_eff      = (bus.lsb_request_in || lsb_pend) && !lsb_drop;
        if_eff       = (bus.if_request_in || if_pend) && !bus.rollback_in;
        if_eff_addr  = bus.if_request_in ? bus.if_address_in : if_addr_q;
        grant_lsb    = (state == IDLE) && lsb_eff;
        grant_if     = (state == IDLE) && !lsb_eff && if_eff;
        sel_addr     = lsb_eff ? lsb_new_addr : if_eff_addr;
        sel_rw       = lsb_eff && lsb_new_rw;
        sel_n        = lsb_eff ? lsb_new_n : 3'd4;
        sel_io       = (sel_addr[17:16] == 2'b11);

        byte_idx = cnt[1:0] - 2'd2;
        asm_next = asm_q;
        if (cnt >= 3'd2) asm_next[{byte_idx, 3'b000} +: 8] = bus.ram_din_in;

        wr_addr  = cur_addr + {29'd0, cnt};
        wr_byte  = cur_data[{cnt[1:0], 3'b000} +: 8];
        wr_stall = (wr_addr[17:16] == 2'b11) && bus.io_buffer_full_in;
        rd_abort = bus.rollback_in && (!cur_lsb || (cur_addr[17:16] != 2'b11));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            if_pend    <= 1'b0;
            if_addr_q  <= '0;
            lsb_pend   <= 1'b0;
            lsb_rw_q   <= 1'b0;
            lsb_addr_q <= '0;
            lsb_n_q    <= '0;
            lsb_data_q <= '0;
            cur_addr   <= '0;
            cur_data   <= '0;
            cur_n      <= '0;
            cur_lsb    <= 1'b0;
            cnt        <= '0;
            asm_q      <= '0;
            if_ready   <= 1'b0;
            if_data    <= '0;
            lsb_ready  <= 1'b0;
            lsb_data   <= '0;
            ram_dout   <= '0;
            ram_a      <= '0;
            ram_wr     <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            lsb_ready <= 1'b0;

            if (bus.rollback_in || grant_if) begin
                if_pend <= 1'b0;
            end else if (bus.if_request_in) begin
                if_pend   <= 1'b1;
                if_addr_q <= bus.if_address_in;
            end

            if (grant_lsb || lsb_drop) begin
                lsb_pend <= 1'b0;
            end else if (bus.lsb_request_in) begin
                lsb_pend   <= 1'b1;
                lsb_rw_q   <= bus.lsb_rw_in;
                lsb_addr_q <= bus.lsb_address_in;
                lsb_n_q    <= lsb_n_in;
                lsb_data_q <= bus.lsb_data_in;
            end

            case (state)
                IDLE: begin
                    if (grant_lsb || grant_if) begin
                        cur_addr <= sel_addr;
                        cur_data <= lsb_new_data;
                        cur_n    <= sel_n;
                        cur_lsb  <= lsb_eff;
                        asm_q    <= '0;
                        if (sel_rw) begin
                            state <= WRITE;
                            if (sel_io && bus.io_buffer_full_in) begin
                                ram_wr <= 1'b0;
                                cnt    <= 3'd0;
                            end else begin
                                ram_a    <= sel_addr;
                                ram_dout <= lsb_new_data[7:0];
                                ram_wr   <= 1'b1;
                                cnt      <= 3'd1;
                            end
                        end else begin
                            state  <= READ;
                            ram_a  <= sel_addr;
                            ram_wr <= 1'b0;
                            cnt    <= 3'd1;
                        end
                    end
                end
                READ: begin
                    if (rd_abort) begin
                        state <= IDLE;
                    end else begin
                        // Address k issues at edge k; its byte lands two edges later.
                        if (cnt < cur_n) ram_a <= cur_addr + {29'd0, cnt};
                        asm_q <= asm_next;
                        cnt   <= cnt + 3'd1;
                        if (cnt == cur_n + 3'd1) begin
                            state <= IDLE;
                            if (cur_lsb) begin
                                lsb_ready <= 1'b1;
                                lsb_data  <= asm_next;
                            end else begin
                                if_ready <= 1'b1;
                                if_data  <= asm_next;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (cnt == cur_n) begin
                        ram_wr    <= 1'b0;
                        lsb_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (wr_stall) begin
                        ram_wr <= 1'b0;
                    end else begin
                        ram_a    <= wr_addr;
                        ram_dout <= wr_byte;
                        ram_wr   <= 1'b1;
                        cnt      <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_ready_out  = if_ready;
    assign bus.if_data_out   = if_data;
    assign bus.lsb_ready_out = lsb_ready;
    assign bus.lsb_data_out  = lsb_data;
    assign bus.ram_dout_out  = ram_dout;
    assign bus.ram_a_out     = ram_a;
    assign bus.ram_wr_out    = ram_wr;
    assign bus.arb_state     = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model on the shared port.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [7:0] mem [0:262143];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read of the address presented in the previous cycle.
    always @(posedge clk) begin
        bus.ram_din_in <= mem[bus.ram_a_out[17:0]];
        if (bus.ram_wr_out) mem[bus.ram_a_out[17:0]] <= bus.ram_dout_out;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts negedges from the request negedge until the chosen ready is seen; -1 on timeout.
    task automatic wait_ready(input bit use_lsb, inout int c);
        while (((use_lsb ? bus.lsb_ready_out : bus.if_ready_out) !== 1'b1) && c < 40) begin
            tick();
            c++;
        end
        if (c >= 40) c = -1;
    endtask

    task automatic lsb_req(input bit rw, input logic [31:0] a, input logic [2:0] g,
                           input logic [31:0] d);
        bus.lsb_request_in = 1'b1;
        bus.lsb_rw_in      = rw;
        bus.lsb_address_in = a;
        bus.lsb_goal_in    = g;
        bus.lsb_data_in    = d;
    endtask

    int  c;
    bit  seen;

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        mem[18'h10]  = 8'h13; mem[18'h11]  = 8'h00; mem[18'h12]  = 8'h00; mem[18'h13] = 8'h93;
        mem[18'h100] = 8'hAA; mem[18'h101] = 8'hBB; mem[18'h102] = 8'hCC; mem[18'h103] = 8'hDD;
        rst = 1'b1;
        bus.rollback_in = 1'b0;
        bus.if_request_in = 1'b0;
        bus.if_address_in = '0;
        bus.lsb_request_in = 1'b0;
        bus.lsb_rw_in = 1'b0;
        bus.lsb_address_in = '0;
        bus.lsb_goal_in = '0;
        bus.lsb_data_in = '0;
        bus.io_buffer_full_in = 1'b0;
        bus.ram_din_in = '0;
        tick(); tick(); tick();

        chk("rst_ram_a", bus.ram_a_out, 32'h0);
        chk("rst_ram_wr", {31'd0, bus.ram_wr_out}, 32'h0);
        chk("rst_readies", {30'd0, bus.if_ready_out, bus.lsb_ready_out}, 32'h0);
        chk("rst_if_data", bus.if_data_out, 32'h0);
        chk("rst_lsb_data", bus.lsb_data_out, 32'h0);
        chk("rst_state", {30'd0, bus.arb_state}, 32'h0);
        rst = 1'b0;
        tick();

        // IF read of 4 bytes at 0x10
        bus.if_request_in = 1'b1; bus.if_address_in = 32'h10;
        tick(); bus.if_request_in = 1'b0; c = 1;
        chk("if_first_addr", bus.ram_a_out, 32'h10);
        wait_ready(1'b0, c);
        chk("if_latency", c, 32'd6);
        chk("if_data", bus.if_data_out, 32'h9300_0013);
        tick();
        chk("if_pulse_len", {31'd0, bus.if_ready_out}, 32'h0);
        tick();

        // Simultaneous LSB (goal 2 @0x100) and IF (@0x10): LSB first, then IF
        lsb_req(1'b0, 32'h100, 3'd2, 32'h0);
        bus.if_request_in = 1'b1; bus.if_address_in = 32'h10;
        tick(); bus.lsb_request_in = 1'b0; bus.if_request_in = 1'b0; c = 1;
        wait_ready(1'b1, c);
        chk("arb_lsb_latency", c, 32'd4);
        chk("arb_lsb_data", bus.lsb_data_out, 32'h0000_BBAA);
        chk("arb_if_not_yet", {31'd0, bus.if_ready_out}, 32'h0);
        wait_ready(1'b0, c);
        chk("arb_if_latency", c, 32'd10);
        chk("arb_if_data", bus.if_data_out, 32'h9300_0013);
        tick(); tick();

        // LSB write goal 4 to 0x200
        lsb_req(1'b1, 32'h200, 3'd4, 32'h1122_3344);
        tick(); bus.lsb_request_in = 1'b0;
        chk("wr_b0", {bus.ram_a_out[15:0], 7'd0, bus.ram_wr_out, bus.ram_dout_out}, 32'h0200_0144);
        tick();
        chk("wr_b1", {bus.ram_a_out[15:0], 7'd0, bus.ram_wr_out, bus.ram_dout_out}, 32'h0201_0133);
        tick();
        chk("wr_b2", {bus.ram_a_out[15:0], 7'd0, bus.ram_wr_out, bus.ram_dout_out}, 32'h0202_0122);
        tick();
        chk("wr_b3", {bus.ram_a_out[15:0], 7'd0, bus.ram_wr_out, bus.ram_dout_out}, 32'h0203_0111);
        tick();
        chk("wr_done", {30'd0, bus.ram_wr_out, bus.lsb_ready_out}, 32'h1);
        tick();
        chk("wr_pulse_len", {31'd0, bus.lsb_ready_out}, 32'h0);
        chk("wr_mem", {mem[18'h203], mem[18'h202], mem[18'h201], mem[18'h200]}, 32'h1122_3344);
        tick();

        // IO write goal 1 to 0x30000 with the IO buffer full for 3 cycles
        lsb_req(1'b1, 32'h30000, 3'd1, 32'h0000_005A);
        bus.io_buffer_full_in = 1'b1;
        tick(); bus.lsb_request_in = 1'b0;
        chk("io_stall1", {31'd0, bus.ram_wr_out}, 32'h0);
        tick();
        chk("io_stall2", {31'd0, bus.ram_wr_out}, 32'h0);
        tick();
        chk("io_stall3", {31'd0, bus.ram_wr_out}, 32'h0);
        bus.io_buffer_full_in = 1'b0;
        tick();
        chk("io_issue", {bus.ram_a_out[19:0], 3'd0, bus.ram_wr_out, bus.ram_dout_out}, 32'h3000_015A);
        tick();
        chk("io_done", {30'd0, bus.ram_wr_out, bus.lsb_ready_out}, 32'h1);
        tick(); tick();

        // Rollback during IF byte 1 with a pending non-IO LSB load
        bus.if_request_in = 1'b1; bus.if_address_in = 32'h10;
        tick(); bus.if_request_in = 1'b0;
        lsb_req(1'b0, 32'h100, 3'd4, 32'h0);
        tick(); bus.lsb_request_in = 1'b0;
        chk("rb_second_byte", bus.ram_a_out, 32'h11);
        bus.rollback_in = 1'b1;
        tick(); bus.rollback_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.if_ready_out === 1'b1 || bus.lsb_ready_out === 1'b1) seen = 1'b1;
            tick();
        end
        chk("rb_no_ready", {31'd0, seen}, 32'h0);
        chk("rb_state_idle", {30'd0, bus.arb_state}, 32'h0);
        bus.if_request_in = 1'b1; bus.if_address_in = 32'h100;
        tick(); bus.if_request_in = 1'b0; c = 1;
        wait_ready(1'b0, c);
        chk("rb_next_if_latency", c, 32'd6);
        chk("rb_next_if_data", bus.if_data_out, 32'hDDCC_BBAA);
        tick(); tick();

        // Rollback during an LSB write of goal 4: all bytes still written
        lsb_req(1'b1, 32'h204, 3'd4, 32'hA5B6_C7D8);
        tick(); bus.lsb_request_in = 1'b0; bus.rollback_in = 1'b1; c = 1;
        tick(); bus.rollback_in = 1'b0; c++;
        wait_ready(1'b1, c);
        chk("rbw_latency", c, 32'd5);
        tick();
        chk("rbw_mem", {mem[18'h207], mem[18'h206], mem[18'h205], mem[18'h204]}, 32'hA5B6_C7D8);
        tick();

        // Goal 3 behaves as 4; goal 1 zero-extends
        lsb_req(1'b0, 32'h10, 3'd3, 32'h0);
        tick(); bus.lsb_request_in = 1'b0; c = 1;
        wait_ready(1'b1, c);
        chk("goal3_latency", c, 32'd6);
        chk("goal3_data", bus.lsb_data_out, 32'h9300_0013);
        tick(); tick();
        lsb_req(1'b0, 32'h13, 3'd1, 32'h0);
        tick(); bus.lsb_request_in = 1'b0; c = 1;
        wait_ready(1'b1, c);
        chk("goal1_latency", c, 32'd3);
        chk("goal1_data", bus.lsb_data_out, 32'h0000_0093);
        tick(); tick();

        // IO read survives rollback
        lsb_req(1'b0, 32'h30000, 3'd1, 32'h0);
        tick(); bus.lsb_request_in = 1'b0; bus.rollback_in = 1'b1; c = 1;
        tick(); bus.rollback_in = 1'b0; c++;
        wait_ready(1'b1, c);
        chk("io_rd_latency", c, 32'd3);
        chk("io_rd_data", bus.lsb_data_out, 32'h0000_005A);
        tick(); tick();

        // Reset in the middle of a write
        lsb_req(1'b1, 32'h208, 3'd4, 32'h0102_0304);
        tick(); bus.lsb_request_in = 1'b0;
        tick(); rst = 1'b1;
        tick();
        chk("midrst_wr", {31'd0, bus.ram_wr_out}, 32'h0);
        chk("midrst_state", {30'd0, bus.arb_state}, 32'h0);
        chk("midrst_ready", {31'd0, bus.lsb_ready_out}, 32'h0);
        rst = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single owner of the 8-bit unified RAM/IO port. Arbitrates between instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes). Serialises each request into byte accesses, assembles read data little-endian and returns a one-cycle ready pulse. Honours pipeline rollback and IO-buffer back-pressure.

## Interface
- No parameters. IO region: address bits [17:16] == 2'b11.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rollback_in  in  1  ROB flush pulse
- if_request_in  in  1  one-cycle fetch request pulse
- if_address_in  in  32  fetch address, valid with request
- if_ready_out  out  1  one-cycle pulse, fetch data valid
- if_data_out  out  32  fetched word
- lsb_request_in  in  1  one-cycle LSB request pulse
- lsb_rw_in  in  1  0 read, 1 write
- lsb_address_in  in  32  byte address
- lsb_goal_in  in  3  byte count: 1, 2 or 4; any other value treated as 4
- lsb_data_in  in  32  write data; low bytes used
- lsb_ready_out  out  1  one-cycle pulse: read data valid / write done
- lsb_data_out  out  32  read data, zero-extended; LSB does sign extension
- ram_din_in  in  8  RAM read byte
- ram_dout_out  out  8  RAM write byte
- ram_a_out  out  32  RAM byte address
- ram_wr_out  out  1  1 write, 0 read
- io_buffer_full_in  in  1  IO write FIFO full

## Operation
- States: IDLE, READ, WRITE.
- Pending slots:
  - One slot per requester latches the request pulse (address, rw, goal, data) on any edge, busy or not.
  - Each requester has at most one outstanding request until its ready.
- Arbitration in IDLE with a pending slot: LSB wins over IF. The winner's slot clears at the acceptance edge E0.
- READ of N bytes:
  - At edge Ek (k = 0..N-1): ram_a_out <= base+k, ram_wr_out <= 0.
  - Byte k is captured from ram_din_in at edge E(k+2) into bits [8k+7:8k]; unfetched upper bits are 0.
  - At E(N+1): ready pulse and data registered, state <= IDLE.
- WRITE of N bytes:
  - At edge Ek: ram_a_out <= base+k, ram_dout_out <= data[8k+7:8k], ram_wr_out <= 1.
  - At E(N): ram_wr_out <= 0, lsb_ready_out pulses, state <= IDLE.
- IO back-pressure: if the write address is in the IO region and io_buffer_full_in is high at the edge where the next byte would issue, drive ram_wr_out <= 0 and do not advance. Retry every cycle.
- Address arithmetic is 32-bit wrap-around; the byte counter is 3 bits.
- Rollback (edge with rollback_in high):
  - In-flight or pending IF read: discarded, no if_ready_out. An if_request_in in the same cycle is ignored.
  - LSB read to a non-IO address, in-flight or pending or arriving: discarded, no ready.
  - LSB IO reads and all LSB writes continue to completion, including a write stalled on IO back-pressure.
  - After an abort, state <= IDLE. ram_wr_out is already 0 during any read.
- When not writing, ram_wr_out is always 0. ram_a_out and ram_dout_out hold their last value.

## Timing
- Reset: state IDLE, slots empty, every output 0 (ram_a_out = 0, ram_wr_out = 0, both ready 0, both data 0).
- Reset mid-transfer aborts immediately; no ready, ram_wr_out = 0 the next cycle.
- Request pulse visible before edge E0 while IDLE with no competitor: the first RAM address is driven in the cycle after E0.
- Read latency: ready high in the cycle after E(N+1), i.e. N+2 cycles after the request.
- Write latency: ready high in the cycle after E(N) plus stall cycles.
- A new transfer can start at the edge after ready is registered. No back-to-back overlap; there is one idle edge between transfers.
- Ready pulses last exactly one cycle. Data outputs hold until the next ready for that requester.

## Test plan
- Reset, then IF read at 0x0000_0010 with RAM bytes 13,00,00,93 (0x10..0x13) -> if_data_out = 0x9300_0013. if_ready_out is a one-cycle pulse 6 cycles after the request.
- LSB and IF request in the same cycle (LSB read, goal 2, at 0x100 holding AA,BB) -> LSB is served first with lsb_data_out = 0x0000_BBAA. IF is served next; no request is lost.
- LSB write, goal 4, data 0x1122_3344 to 0x200 -> writes 44,33,22,11 at 0x200..0x203 on consecutive cycles with ram_wr_out high 4 cycles. lsb_ready_out pulses once.
- LSB write, goal 1, to 0x30000 with io_buffer_full_in high for 3 cycles -> ram_wr_out stays 0 for 3 cycles. Then one write of the byte, then ready.
- Rollback during the second byte of an IF read and during a pending non-IO LSB load -> neither ready ever pulses, state IDLE. The next IF request completes normally.
- Rollback during an LSB write of goal 4 -> all 4 bytes are written and lsb_ready_out pulses.
